bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one bit per clock. It sits upstream of the calculator's 7-segment display decoders. It converts the ALU's binary result into packed 4-bit BCD digits, one per display decoder input. A start/busy/done handshake lets the calculator control FSM launch a conversion and latch the result.

Parameters:
WIDTH, 8, bit width of binary input; must be >= 1.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1 (elaboration-time check, fatal on violation).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request conversion of bin_in; sampled only in IDLE.
bin_in  input  WIDTH  binary operand, captured on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd_out is updated.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].
sign_out  output  1  negative-result flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, sign_out=0, internal shift/count registers=0. Reset mid-conversion aborts immediately. No done pulse. bcd_out returns to 0.
- States: IDLE, SHIFT.
- IDLE: on an edge with start=1, load the binary shift register with bin_in and clear the BCD scratch register and the iteration counter. Set busy=1 and go to SHIFT. start=0 keeps IDLE; outputs are held.
- SHIFT: each edge performs one iteration.
  - Every scratch digit >= 5 gets +3 (4-bit, no carry out of the digit).
  - Then {scratch, binary} is shifted left by 1.
  - counter increments.
- On the WIDTH-th iteration edge:
  - bcd_out <= final scratch value.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high exactly WIDTH cycles after the start-accepting edge. For WIDTH=8, start accepted at edge 0 gives done high after edge 8.
- done is a single-cycle pulse; it clears on the next edge unconditionally.
- start while busy=1: ignored, with no effect on the current conversion. It is not queued.
- start high in the cycle done is high: state is IDLE, so it is accepted. busy rises on the next edge and done falls on the same edge. The previous bcd_out is held until the new completion.
- bcd_out changes only on a completion edge or on reset. It is stable whenever busy=1.
- Counter width: clog2(WIDTH+1). Scratch width: 4*DIGITS. No overflow is possible given the DIGITS constraint.

Optional Feature:
Macro BIN2BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - On accept, the magnitude (negated value when the MSB is 1) is loaded. The sign bit is registered and driven on sign_out, updated on the completion edge together with bcd_out.
  - The most negative value converts to magnitude 2^(WIDTH-1); for WIDTH=8, 8'h80 gives 128.
  - Latency is unchanged.
- Undefined: bin_in is unsigned and sign_out is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W=4 digit-width constant.
  - ADJ_THRESH=5 and ADJ_ADD=3 constants.
  - The IDLE/SHIFT state enum.
  - A 4-bit BCD digit typedef.
- One natural sub-module, bcd_digit_adj: combinational, 4-bit in, 4-bit out, output = in+3 when in >= 5, else in. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then start with bin_in=0 -> done pulses after 8 cycles, bcd_out=12'h000, busy high for exactly 8 cycles.
- bin_in=8'd255 -> bcd_out=12'h255. bin_in=8'd99 -> 12'h099. bin_in=8'd100 -> 12'h100. Exhaustive sweep 0..255 against a reference model.
- start=1 held continuously with bin_in changing every cycle -> conversions back-to-back. Each result matches bin_in sampled at its accepting edge (the edge after each done). No done pulse is missed.
- Pulse start during busy with a different bin_in -> ignored; the result matches the original operand and done occurs only once.
- Assert rst at cycle 4 of a conversion -> busy=0, bcd_out=0, no done. A subsequent start of 8'd42 -> 12'h042.
- BIN2BCD_SIGNED_EN build: 8'h80 -> sign_out=1, bcd_out=12'h128. 8'hFF -> sign_out=1, 12'h001. 8'd127 -> sign_out=0, 12'h127.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: digit type,
// add-3 constants, FSM state encoding and the parameter sanity check.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t ADJ_THRESH = 4'd5;
    localparam bcd_digit_t ADJ_ADD    = 4'd3;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_fit(int unsigned w, int unsigned d);
        longint unsigned maxv;
        longint unsigned p;
        maxv = (64'd1 << w) - 64'd1;
        p    = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p > maxv;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    always_comb begin
        q = d;
        if (d >= ADJ_THRESH) begin
            q = d + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 iteration per clock.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement (magnitude + sign_out).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      sign_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = BCD_W * DIGITS;

    if (WIDTH < 1 || !digits_fit(WIDTH, DIGITS)) begin : g_bad_cfg
        $fatal(1, "bin_to_bcd_seq: DIGITS too small for WIDTH (or WIDTH < 1)");
    end

    state_t              state;
    logic [WIDTH-1:0]    bin_sh;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [CW-1:0]       cnt;
    logic [SW+WIDTH-1:0] shifted;
    logic [WIDTH-1:0]    load_val;
    logic                last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[g*BCD_W +: BCD_W]),
            .q (adj[g*BCD_W +: BCD_W])
        );
    end

    assign shifted = {adj, bin_sh} << 1;
    assign last    = (cnt == CW'(WIDTH - 1));

`ifdef BIN2BCD_SIGNED_EN
    logic sign_pend;

    // The most negative value negates to itself, which reads correctly as unsigned.
    assign load_val = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
`else
    assign load_val = bin_in;
    assign sign_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bin_sh  <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_pend <= 1'b0;
            sign_out  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sh  <= load_val;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                        sign_pend <= bin_in[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    scratch <= shifted[SW+WIDTH-1:WIDTH];
                    bin_sh  <= shifted[WIDTH-1:0];
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        bcd_out <= shifted[SW+WIDTH-1:WIDTH];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
`ifdef BIN2BCD_SIGNED_EN
                        sign_out <= sign_pend;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
